// File: rtl/mcore_xmem_arbiter.sv
// Shares one external mem_if port between NUM_REQ masters: round-robin grant, lock until mem_gnt, in-order response routing.
// Optional feature macro MCORE_XARB_PRIO_EN: master 0 gets fixed top priority, masters 1..NUM_REQ-1 round-robin.
module mcore_xmem_arbiter #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [NUM_REQ-1:0]              s_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   s_addr,
  input  logic [NUM_REQ-1:0]              s_we,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   s_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] s_be,
  output logic [NUM_REQ-1:0]              s_gnt,
  output logic [NUM_REQ-1:0]              s_rsp_valid,
  output logic [DATA_WIDTH-1:0]           s_rsp_rdata,
  output logic                            s_rsp_error,
  output logic                            mem_req,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic                            mem_we,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  output logic [DATA_WIDTH/8-1:0]         mem_be,
  input  logic                            mem_gnt,
  input  logic                            mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]           mem_rsp_rdata,
  input  logic                            mem_rsp_error,
  output logic                            busy,
  output logic                            stray_rsp
);

  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned ID_WIDTH  = $clog2(NUM_REQ);
  localparam int unsigned PTR_WIDTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t               state_q, state_n;
  logic [ID_WIDTH-1:0]  lock_id_q, lock_id_n;
  logic [ID_WIDTH-1:0]  rr_ptr_q, rr_ptr_n;
  logic [ID_WIDTH-1:0]  fifo_q [MAX_OUTSTANDING];
  logic [PTR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 stray_q;

  logic [ID_WIDTH-1:0]  arb_pick, owner, head_id;
  logic                 found, fifo_full, fifo_empty, req_ok, push, pop;
  int unsigned          cand, base;

  assign fifo_full  = (count_q == CNT_WIDTH'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);
  assign head_id    = fifo_q[rd_ptr_q];
  assign stray_rsp  = stray_q;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    if (32'(p) == MAX_OUTSTANDING - 1) return '0;
    return p + PTR_WIDTH'(1);
  endfunction

  // Round-robin pointer after a grant to id
  function automatic logic [ID_WIDTH-1:0] next_ptr(input logic [ID_WIDTH-1:0] id);
`ifdef MCORE_XARB_PRIO_EN
    if (id == '0) return rr_ptr_q;
    if (32'(id) == NUM_REQ - 1) return ID_WIDTH'(1);
    return id + ID_WIDTH'(1);
`else
    if (32'(id) == NUM_REQ - 1) return '0;
    return id + ID_WIDTH'(1);
`endif
  endfunction

  // Idle-state owner: first requester at or after the rr pointer
  always_comb begin
    arb_pick = rr_ptr_q;
    found    = 1'b0;
    cand     = 32'd0;
`ifdef MCORE_XARB_PRIO_EN
    base = (rr_ptr_q == '0) ? 32'd0 : 32'(rr_ptr_q) - 32'd1;
    if (s_req[0]) begin
      arb_pick = '0;
      found    = 1'b1;
    end
    for (int unsigned k = 0; k < NUM_REQ - 1; k++) begin
      cand = 32'd1 + ((base + k) % (NUM_REQ - 1));
      if (!found && s_req[ID_WIDTH'(cand)]) begin
        arb_pick = ID_WIDTH'(cand);
        found    = 1'b1;
      end
    end
`else
    base = 32'(rr_ptr_q);
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (base + k) % NUM_REQ;
      if (!found && s_req[ID_WIDTH'(cand)]) begin
        arb_pick = ID_WIDTH'(cand);
        found    = 1'b1;
      end
    end
`endif
  end

  // Lock FSM next state, pass-through handshake and response routing
  always_comb begin
    state_n     = state_q;
    lock_id_n   = lock_id_q;
    rr_ptr_n    = rr_ptr_q;
    s_gnt       = '0;
    s_rsp_valid = '0;
    s_rsp_rdata = '0;
    s_rsp_error = 1'b0;
    mem_req     = 1'b0;
    mem_addr    = '0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    mem_be      = '0;
    busy        = 1'b0;

    owner  = (state_q == S_LOCKED) ? lock_id_q : arb_pick;
    req_ok = ~areset & s_req[owner] & ~fifo_full;
    push   = req_ok & mem_gnt;
    pop    = ~areset & mem_rsp_valid & ~fifo_empty;

    case (state_q)
      S_IDLE: begin
        if (req_ok && !mem_gnt) begin
          state_n   = S_LOCKED;
          lock_id_n = owner;
        end
      end
      S_LOCKED: begin
        if (push) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    if (push) rr_ptr_n = next_ptr(owner);

    mem_req = req_ok;
    if (req_ok) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (ID_WIDTH'(i) == owner) begin
          mem_addr  = s_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          mem_we    = s_we[i];
          mem_wdata = s_wdata[i*DATA_WIDTH +: DATA_WIDTH];
          mem_be    = s_be[i*BE_WIDTH +: BE_WIDTH];
        end
      end
    end
    if (push) s_gnt[owner] = 1'b1;

    if (pop) begin
      s_rsp_valid[head_id] = 1'b1;
      s_rsp_rdata          = mem_rsp_rdata;
      s_rsp_error          = mem_rsp_error;
    end

    busy = ~areset & ((state_q == S_LOCKED) | ~fifo_empty | req_ok);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= S_IDLE;
      lock_id_q <= '0;
      rr_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      stray_q   <= 1'b0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) fifo_q[i] <= '0;
    end else begin
      state_q   <= state_n;
      lock_id_q <= lock_id_n;
      rr_ptr_q  <= rr_ptr_n;
      if (push) begin
        fifo_q[wr_ptr_q] <= owner;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_WIDTH'(1);
        2'b01:   count_q <= count_q - CNT_WIDTH'(1);
        default: count_q <= count_q;
      endcase
      if (mem_rsp_valid && fifo_empty) stray_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mcore_xmem_arbiter.sv
// Directed bench for mcore_xmem_arbiter: per-cycle queue-based model check plus hand-computed literal checks.
module tb_mcore_xmem_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned MO = 4;
  localparam int unsigned BW = DW / 8;

  logic              aclk = 1'b0;
  logic              areset;
  logic [N-1:0]      s_req, s_we, s_gnt, s_rsp_valid;
  logic [N*AW-1:0]   s_addr;
  logic [N*DW-1:0]   s_wdata;
  logic [N*BW-1:0]   s_be;
  logic [DW-1:0]     s_rsp_rdata, mem_wdata, mem_rsp_rdata;
  logic [AW-1:0]     mem_addr;
  logic [BW-1:0]     mem_be;
  logic              s_rsp_error, mem_req, mem_we, mem_gnt, mem_rsp_valid, mem_rsp_error, busy, stray_rsp;

  int n_vec = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  mcore_xmem_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)) dut (
    .aclk(aclk), .areset(areset),
    .s_req(s_req), .s_addr(s_addr), .s_we(s_we), .s_wdata(s_wdata), .s_be(s_be),
    .s_gnt(s_gnt), .s_rsp_valid(s_rsp_valid), .s_rsp_rdata(s_rsp_rdata), .s_rsp_error(s_rsp_error),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .mem_rsp_error(mem_rsp_error), .busy(busy), .stray_rsp(stray_rsp)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: lock, rr pointer, queue of granted master ids, sticky stray flag
  int m_ptr, m_lock, q[$];
  bit m_locked, m_stray;

  function automatic int model_owner();
    int c;
    if (m_locked) return m_lock;
`ifdef MCORE_XARB_PRIO_EN
    if (s_req[0]) return 0;
    c = (m_ptr == 0) ? 1 : m_ptr;
    for (int k = 0; k < N - 1; k++) begin
      if (s_req[c]) return c;
      c = (c == N - 1) ? 1 : c + 1;
    end
`else
    for (int k = 0; k < N; k++) begin
      c = (m_ptr + k) % N;
      if (s_req[c]) return c;
    end
`endif
    return m_ptr;
  endfunction

  initial begin : model_cmp
    int own;
    bit ereq, hs, e_we, e_err, e_busy, e_stray;
    logic [N-1:0] e_gnt, e_rv;
    logic [31:0] e_addr, e_wd, e_rd;
    logic [BW-1:0] e_be;
    m_ptr = 0; m_lock = 0; m_locked = 0; m_stray = 0;
    forever begin
      @(negedge aclk);
      e_gnt = '0; e_rv = '0; e_addr = '0; e_wd = '0; e_rd = '0; e_be = '0;
      e_we = 0; e_err = 0; e_busy = 0; ereq = 0; hs = 0; own = 0;
      e_stray = areset ? 1'b0 : m_stray;
      if (!areset) begin
        own  = model_owner();
        ereq = s_req[own] && (q.size() < MO);
        hs   = ereq && mem_gnt;
        if (ereq) begin
          e_addr = s_addr[own*AW +: AW];
          e_we   = s_we[own];
          e_wd   = s_wdata[own*DW +: DW];
          e_be   = s_be[own*BW +: BW];
        end
        if (hs) e_gnt[own] = 1'b1;
        if (mem_rsp_valid && q.size() > 0) begin
          e_rv[q[0]] = 1'b1;
          e_rd       = mem_rsp_rdata;
          e_err      = mem_rsp_error;
        end
        e_busy = m_locked || (q.size() > 0) || ereq;
      end
      chk("s_gnt", 64'(s_gnt), 64'(e_gnt));
      chk("mem_req", 64'(mem_req), 64'(ereq));
      chk("mem_addr", 64'(mem_addr), 64'(e_addr));
      chk("mem_we", 64'(mem_we), 64'(e_we));
      chk("mem_wdata", 64'(mem_wdata), 64'(e_wd));
      chk("mem_be", 64'(mem_be), 64'(e_be));
      chk("s_rsp_valid", 64'(s_rsp_valid), 64'(e_rv));
      chk("s_rsp_rdata", 64'(s_rsp_rdata), 64'(e_rd));
      chk("s_rsp_error", 64'(s_rsp_error), 64'(e_err));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("stray_rsp", 64'(stray_rsp), 64'(e_stray));
      if (areset) begin
        m_ptr = 0; m_lock = 0; m_locked = 0; m_stray = 0;
        q.delete();
      end else begin
        if (mem_rsp_valid) begin
          if (q.size() > 0) void'(q.pop_front());
          else m_stray = 1;
        end
        if (hs) begin
          q.push_back(own);
          m_locked = 0;
`ifdef MCORE_XARB_PRIO_EN
          if (own != 0) m_ptr = (own == N - 1) ? 1 : own + 1;
`else
          m_ptr = (own + 1) % N;
`endif
        end else if (ereq) begin
          m_locked = 1;
          m_lock   = own;
        end
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] req, input logic g, input logic rv, input logic [31:0] rd);
    s_req = req; mem_gnt = g; mem_rsp_valid = rv; mem_rsp_rdata = rd; mem_rsp_error = rd[0];
  endtask

  task automatic reset_pulse();
    tick();
    areset = 1'b1;
    drive('0, 1'b0, 1'b0, 32'h0);
    tick();
    areset = 1'b0;
  endtask

  initial begin
    areset = 1'b1;
    drive('0, 1'b0, 1'b0, 32'h0);
    s_we = 4'b1010;
    for (int i = 0; i < N; i++) begin
      s_addr[i*AW +: AW]  = 32'h1000_0000 + 32'(i * 16);
      s_wdata[i*DW +: DW] = 32'hA000_0000 + 32'(i);
      s_be[i*BW +: BW]    = BW'(i + 1);
    end
    s_addr[2*AW +: AW] = 32'h0027_1bd0;
    tick();
    tick();
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_stray", 64'(stray_rsp), 64'h0);
    areset = 1'b0;

    // Single read by master 2, response two cycles after grant
    tick(); drive(4'b0100, 1'b1, 1'b0, 32'h0); #1;
    chk("t1_gnt", 64'(s_gnt), 64'h4);
    chk("t1_addr", 64'(mem_addr), 64'h271bd0);
    tick(); drive('0, 1'b0, 1'b0, 32'h0); #1;
    chk("t1_busy_wait", 64'(busy), 64'h1);
    tick(); drive('0, 1'b0, 1'b1, 32'h7fff); #1;
    chk("t1_rsp", 64'(s_rsp_valid), 64'h4);
    chk("t1_rdata", 64'(s_rsp_rdata), 64'h7fff);
    tick(); drive('0, 1'b0, 1'b0, 32'h0); #1;
    chk("t1_idle", 64'(busy), 64'h0);

    // All four request continuously, immediate responses
    reset_pulse();
    for (int k = 0; k < 9; k++) begin
      tick();
      drive((k < 8) ? 4'hf : 4'h0, k < 8, k >= 1, 32'h1000 + 32'(k));
      #1;
      if (k < 8) chk("t2_gnt", 64'(s_gnt), 64'(1 << (k % 4)));
      if (k >= 1) chk("t2_rsp", 64'(s_rsp_valid), 64'(1 << ((k - 1) % 4)));
    end

    // Lock: master 1 waits five cycles for mem_gnt while master 0 also requests
    tick(); drive(4'b0010, 1'b0, 1'b0, 32'h0); #1;
    chk("t3_addr0", 64'(mem_addr), 64'h1000_0010);
    for (int k = 1; k < 5; k++) begin
      tick(); drive(4'b0011, 1'b0, 1'b0, 32'h0); #1;
      chk("t3_addr_lock", 64'(mem_addr), 64'h1000_0010);
      chk("t3_nognt", 64'(s_gnt), 64'h0);
    end
    tick(); drive(4'b0011, 1'b1, 1'b0, 32'h0); #1;
    chk("t3_gnt1", 64'(s_gnt), 64'h2);
    tick(); drive(4'b0001, 1'b1, 1'b0, 32'h0); #1;
    chk("t3_gnt0", 64'(s_gnt), 64'h1);
    tick(); drive('0, 1'b0, 1'b1, 32'h33); #1;
    chk("t3_rsp1", 64'(s_rsp_valid), 64'h2);
    tick(); drive('0, 1'b0, 1'b1, 32'h44); #1;
    chk("t3_rsp0", 64'(s_rsp_valid), 64'h1);

    // FIFO full, pop frees a slot only on the next cycle
    for (int k = 0; k < 4; k++) begin
      tick(); drive(4'hf, 1'b1, 1'b0, 32'h0); #1;
      chk("t4_fill_gnt", 64'(s_gnt), 64'(1 << ((k + 1) % 4)));
    end
    tick(); drive(4'hf, 1'b1, 1'b0, 32'h0); #1;
    chk("t4_full_req", 64'(mem_req), 64'h0);
    tick(); drive(4'hf, 1'b1, 1'b1, 32'h55); #1;
    chk("t4_pop_req", 64'(mem_req), 64'h0);
    chk("t4_pop_rsp", 64'(s_rsp_valid), 64'h2);
    tick(); drive(4'hf, 1'b1, 1'b1, 32'h66); #1;
    chk("t4_regnt", 64'(s_gnt), 64'h2);
    chk("t4_rsp2", 64'(s_rsp_valid), 64'h4);
    tick(); drive(4'hf, 1'b1, 1'b1, 32'h77); #1;
    chk("t4_gnt2", 64'(s_gnt), 64'h4);
    chk("t4_rsp3", 64'(s_rsp_valid), 64'h8);
    tick(); drive(4'hf, 1'b1, 1'b0, 32'h0); #1;
    chk("t4_gnt3", 64'(s_gnt), 64'h8);
    tick(); drive(4'hf, 1'b1, 1'b1, 32'h99); #1;
    chk("t4_full_pop_req", 64'(mem_req), 64'h0);
    chk("t4_rsp0", 64'(s_rsp_valid), 64'h1);
    for (int k = 0; k < 3; k++) begin
      tick(); drive('0, 1'b0, 1'b1, 32'hb0 + 32'(k)); #1;
      chk("t4_drain", 64'(s_rsp_valid), 64'(2 << k));
    end
    tick(); drive('0, 1'b0, 1'b0, 32'h0); #1;
    chk("t4_idle", 64'(busy), 64'h0);

    // Stray response with empty FIFO
    tick(); drive('0, 1'b0, 1'b1, 32'hdead); #1;
    chk("t5_no_rsp", 64'(s_rsp_valid), 64'h0);
    tick(); drive('0, 1'b0, 1'b0, 32'h0); #1;
    chk("t5_stray", 64'(stray_rsp), 64'h1);
    tick(); #1;
    chk("t5_stray_held", 64'(stray_rsp), 64'h1);
    reset_pulse();
    tick(); #1;
    chk("t5_stray_clr", 64'(stray_rsp), 64'h0);

    // Reset with three outstanding and a locked request
    for (int k = 0; k < 3; k++) begin
      tick(); drive(4'b0111, 1'b1, 1'b0, 32'h0); #1;
      chk("t6_gnt", 64'(s_gnt), 64'(1 << k));
    end
    tick(); drive(4'b1000, 1'b0, 1'b0, 32'h0); #1;
    chk("t6_busy", 64'(busy), 64'h1);
    tick(); drive(4'b1000, 1'b1, 1'b0, 32'h0);
    areset = 1'b1; #1;
    chk("t6_rst_req", 64'(mem_req), 64'h0);
    chk("t6_rst_gnt", 64'(s_gnt), 64'h0);
    chk("t6_rst_busy", 64'(busy), 64'h0);
    chk("t6_rst_addr", 64'(mem_addr), 64'h0);
    tick(); areset = 1'b0; drive('0, 1'b0, 1'b0, 32'h0);
    tick(); drive('0, 1'b0, 1'b1, 32'h1234); #1;
    chk("t6_late_rsp", 64'(s_rsp_valid), 64'h0);
    chk("t6_late_rdata", 64'(s_rsp_rdata), 64'h0);
    tick(); drive('0, 1'b0, 1'b0, 32'h0); #1;
    chk("t6_stray", 64'(stray_rsp), 64'h1);

    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
